// File: rtl/project_pkg.sv
// Shared types for the fetch path: machine word, fetch FSM states and FIFO entry layout.
package project_pkg;

  localparam int unsigned WORD_W = 16;

  typedef logic [WORD_W-1:0] word;

  typedef enum logic [1:0] {
    F_IDLE,
    F_INSTR,
    F_IMM
  } e_fetch_state;

  typedef struct packed {
    word pc;
    word instr;
    word imm;
  } fetch_entry_t;

endpackage

// File: rtl/instr_fetch_if.sv
// Fetch-unit bus bundle: program-memory read port, core-side entry stream and redirect.
interface instr_fetch_if;
  import project_pkg::*;

  logic redirect;
  word  redirect_pc;

  logic out_valid;
  logic out_ready;
  word  out_pc;
  word  out_instr;
  word  out_imm;

  word  mem_addr;
  logic mem_req;
  logic mem_ack;
  word  mem_rd_data;

  // master: the fetch unit; slave: memory plus core
  modport master (
    input  redirect, redirect_pc, out_ready, mem_ack, mem_rd_data,
    output out_valid, out_pc, out_instr, out_imm, mem_addr, mem_req
  );

  modport slave (
    output redirect, redirect_pc, out_ready, mem_ack, mem_rd_data,
    input  out_valid, out_pc, out_instr, out_imm, mem_addr, mem_req
  );

endinterface

// File: rtl/fetch_fifo.sv
// Register-array FIFO of fetch entries with wrapping pointers; flush empties it in one cycle.
module fetch_fifo
  import project_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  fetch_entry_t             wdata,
  output fetch_entry_t             rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  fetch_entry_t      mem_q [DEPTH];
  logic [AW-1:0]     wptr_q;
  logic [AW-1:0]     rptr_q;
  logic [AW:0]       count_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else if (flush) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) begin
        mem_q[wptr_q] <= wdata;
        wptr_q        <= wptr_q + AW'(1);
      end
      if (pop) begin
        rptr_q <= rptr_q + AW'(1);
      end
      count_q <= count_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    end
  end

  assign rdata = mem_q[rptr_q];
  assign count = count_q;
  assign full  = (count_q == (AW+1)'(DEPTH));
  assign empty = (count_q == '0);

endmodule

// File: rtl/instr_fetch.sv
// Prefetching two-word instruction fetch unit feeding a small FIFO; redirect flushes and restarts.
// Optional IFETCH_BYPASS_EN: forward the completing entry straight to the core when the FIFO is empty.
module instr_fetch
  import project_pkg::*;
#(
  parameter int unsigned DEPTH    = 4,
  parameter word         RESET_PC = '0
) (
  input logic           clk,
  input logic           rst,
  instr_fetch_if.master bus
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  e_fetch_state state_q;
  word          fpc_q;
  word          hold_instr_q;
  word          hold_pc_q;
  logic         mem_req_q;
  word          mem_addr_q;

  fetch_entry_t push_entry;
  fetch_entry_t fifo_rdata;
  logic [CW-1:0] fifo_count;
  logic         fifo_full;
  logic         fifo_empty;
  logic         fifo_pop;
  logic         push;
  logic         imm_ack;
  logic         bypass_take;
  logic [CW:0]  cnt_after;
  logic         space_after;

  assign imm_ack    = (state_q == F_IMM) & bus.mem_ack & ~bus.redirect;
  assign fifo_pop   = ~fifo_empty & bus.out_ready & ~bus.redirect;
  assign push       = imm_ack & ~bypass_take;
  assign push_entry = '{pc: hold_pc_q, instr: hold_instr_q, imm: bus.mem_rd_data};

`ifdef IFETCH_BYPASS_EN
  logic bypass;
  assign bypass         = imm_ack & fifo_empty;
  assign bypass_take    = bypass & bus.out_ready;
  assign bus.out_valid  = bypass | ~fifo_empty;
  assign bus.out_pc     = bypass ? hold_pc_q     : fifo_rdata.pc;
  assign bus.out_instr  = bypass ? hold_instr_q  : fifo_rdata.instr;
  assign bus.out_imm    = bypass ? bus.mem_rd_data : fifo_rdata.imm;
`else
  assign bypass_take    = 1'b0;
  assign bus.out_valid  = ~fifo_empty;
  assign bus.out_pc     = fifo_rdata.pc;
  assign bus.out_instr  = fifo_rdata.instr;
  assign bus.out_imm    = fifo_rdata.imm;
`endif

  // Occupancy once this cycle's push/pop land; decides whether to start the next fetch
  assign cnt_after   = {1'b0, fifo_count} + {{CW{1'b0}}, push} - {{CW{1'b0}}, fifo_pop};
  assign space_after = (cnt_after < (CW+1)'(DEPTH));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= F_IDLE;
      fpc_q        <= RESET_PC;
      hold_instr_q <= '0;
      hold_pc_q    <= '0;
      mem_req_q    <= 1'b0;
      mem_addr_q   <= '0;
    end else if (bus.redirect) begin
      state_q   <= F_IDLE;
      fpc_q     <= bus.redirect_pc;
      mem_req_q <= 1'b0;
    end else begin
      unique case (state_q)
        F_IDLE: begin
          if (!fifo_full) begin
            state_q    <= F_INSTR;
            mem_req_q  <= 1'b1;
            mem_addr_q <= fpc_q;
          end
        end
        F_INSTR: begin
          if (bus.mem_ack) begin
            hold_instr_q <= bus.mem_rd_data;
            hold_pc_q    <= fpc_q;
            fpc_q        <= fpc_q + word'(1);
            mem_addr_q   <= fpc_q + word'(1);
            state_q      <= F_IMM;
          end
        end
        F_IMM: begin
          if (bus.mem_ack) begin
            fpc_q <= fpc_q + word'(1);
            if (space_after) begin
              state_q    <= F_INSTR;
              mem_addr_q <= fpc_q + word'(1);
            end else begin
              state_q   <= F_IDLE;
              mem_req_q <= 1'b0;
            end
          end
        end
        default: begin
          state_q   <= F_IDLE;
          mem_req_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.mem_req  = mem_req_q;
  assign bus.mem_addr = mem_addr_q;

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (fifo_pop),
    .flush (bus.redirect),
    .wdata (push_entry),
    .rdata (fifo_rdata),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: directed scenarios queue expected entries, a monitor checks pops.
module tb_instr_fetch;
  import project_pkg::*;

`ifdef IFETCH_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk;
  logic rst;
  int   checks;
  int   failures;
  int   delay;
  int   wait_cnt;
  fetch_entry_t sb[$];

  instr_fetch_if bus();

  instr_fetch #(
    .DEPTH    (4),
    .RESET_PC (16'h0000)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: data = addr + 0x10, ack after 'delay' extra request cycles
  always @(posedge clk) begin
    if (bus.mem_req && !bus.mem_ack) wait_cnt <= wait_cnt + 1;
    else                             wait_cnt <= 0;
  end
  assign bus.mem_ack     = bus.mem_req && (wait_cnt >= delay);
  assign bus.mem_rd_data = bus.mem_addr + 16'h0010;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic expect_entry(input word pc, input word instr, input word imm);
    fetch_entry_t e;
    e.pc = pc;
    e.instr = instr;
    e.imm = imm;
    sb.push_back(e);
  endtask

  task automatic drain(input string name, input int budget);
    bus.out_ready = 1'b1;
    for (int i = 0; i < budget && sb.size() != 0; i++) step(1);
    bus.out_ready = 1'b0;
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL %s: %0d entries never delivered, required 0", name, sb.size());
      sb.delete();
    end
  endtask

  task automatic do_redirect(input word pc);
    bus.redirect    = 1'b1;
    bus.redirect_pc = pc;
    sb.delete();
    step(1);
    bus.redirect = 1'b0;
  endtask

  // Monitor: every accepted entry must match the head of the scoreboard
  initial begin
    fetch_entry_t exp;
    forever begin
      @(negedge clk);
      if (rst && bus.out_valid && bus.out_ready) begin
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL pop_unexpected: got pc=%h, required no entry", bus.out_pc);
        end else begin
          exp = sb.pop_front();
          if (bus.out_pc != exp.pc || bus.out_instr != exp.instr || bus.out_imm != exp.imm) begin
            failures++;
            $display("FAIL pop_entry: got pc=%h instr=%h imm=%h, required pc=%h instr=%h imm=%h",
                     bus.out_pc, bus.out_instr, bus.out_imm, exp.pc, exp.instr, exp.imm);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0;
    failures = 0;
    delay = 0;
    rst = 1'b0;
    bus.redirect = 1'b0;
    bus.redirect_pc = '0;
    bus.out_ready = 1'b0;

    // Reset values
    #1;
    check("rst_mem_req", bus.mem_req, 0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_mem_addr", bus.mem_addr, 0);
    check("rst_out_pc", bus.out_pc, 0);
    check("rst_out_imm", bus.out_imm, 0);
    step(2);
    rst = 1'b1;
    check("rel_mem_req", bus.mem_req, 0);
    check("rel_out_valid", bus.out_valid, 0);
    check("rel_out_instr", bus.out_instr, 0);

    // Zero-wait startup and first-entry latency
    step(1);
    check("c2_mem_req", bus.mem_req, 1);
    check("c2_mem_addr", bus.mem_addr, 16'h0000);
    step(1);
    check("c3_mem_addr", bus.mem_addr, 16'h0001);
    check("c3_out_valid", bus.out_valid, BYP);
    step(1);
    check("c4_out_valid", bus.out_valid, 1);
    check("c4_out_pc", bus.out_pc, 16'h0000);
    check("c4_out_instr", bus.out_instr, 16'h0010);
    check("c4_out_imm", bus.out_imm, 16'h0011);
    check("c4_mem_addr", bus.mem_addr, 16'h0002);

    // Fill with out_ready=0: DEPTH entries then the request drops
    step(5);
    check("c9_mem_addr", bus.mem_addr, 16'h0007);
    step(1);
    check("full_mem_req", bus.mem_req, 0);
    step(3);
    check("full_mem_req_hold", bus.mem_req, 0);
    check("full_out_instr_stable", bus.out_instr, 16'h0010);
    expect_entry(16'h0000, 16'h0010, 16'h0011);
    expect_entry(16'h0002, 16'h0012, 16'h0013);
    expect_entry(16'h0004, 16'h0014, 16'h0015);
    expect_entry(16'h0006, 16'h0016, 16'h0017);

    // One pop frees one slot: exactly one more instruction is fetched
    bus.out_ready = 1'b1;
    step(1);
    bus.out_ready = 1'b0;
    check("pop1_mem_req_c1", bus.mem_req, 0);
    step(1);
    check("pop1_mem_req_c2", bus.mem_req, 1);
    check("pop1_mem_addr_c2", bus.mem_addr, 16'h0008);
    step(1);
    check("pop1_mem_addr_c3", bus.mem_addr, 16'h0009);
    step(1);
    check("pop1_mem_req_c4", bus.mem_req, 0);
    step(3);
    check("pop1_mem_req_hold", bus.mem_req, 0);
    expect_entry(16'h0008, 16'h0018, 16'h0019);
    drain("drain_startup", 40);

    // Three-cycle ack delay: address and request held stable
    delay = 3;
    do_redirect(16'h0020);
    check("wait_idle_req", bus.mem_req, 0);
    step(1);
    for (int i = 0; i < 4; i++) begin
      check("wait_req_a", bus.mem_req, 1);
      check("wait_addr_a", bus.mem_addr, 16'h0020);
      step(1);
    end
    for (int i = 0; i < 4; i++) begin
      check("wait_addr_b", bus.mem_addr, 16'h0021);
      step(1);
    end
    check("wait_addr_c", bus.mem_addr, 16'h0022);
    expect_entry(16'h0020, 16'h0030, 16'h0031);
    expect_entry(16'h0022, 16'h0032, 16'h0033);
    drain("drain_wait", 60);
    delay = 0;

    // Redirect during F_IMM with simultaneous ack drops that entry
    do_redirect(16'h0030);
    check("redir_idle_req", bus.mem_req, 0);
    step(1);
    check("redir_instr_addr", bus.mem_addr, 16'h0030);
    step(1);
    check("redir_imm_addr", bus.mem_addr, 16'h0031);
    check("redir_imm_ack", bus.mem_ack, 1);
    bus.redirect    = 1'b1;
    bus.redirect_pc = 16'h0040;
    step(1);
    bus.redirect = 1'b0;
    check("redir_req_drop", bus.mem_req, 0);
    check("redir_out_valid", bus.out_valid, 0);
    step(1);
    check("redir_new_req", bus.mem_req, 1);
    check("redir_new_addr", bus.mem_addr, 16'h0040);
    expect_entry(16'h0040, 16'h0050, 16'h0051);
    drain("drain_redirect", 20);

    // Push and pop together at count=DEPTH-1: fetching continues, order kept
    do_redirect(16'h0050);
    step(7);
    check("pp_addr_c8", bus.mem_addr, 16'h0056);
    step(1);
    check("pp_addr_c9", bus.mem_addr, 16'h0057);
    expect_entry(16'h0050, 16'h0060, 16'h0061);
    bus.out_ready = 1'b1;
    step(1);
    bus.out_ready = 1'b0;
    check("pp_req_c10", bus.mem_req, 1);
    check("pp_addr_c10", bus.mem_addr, 16'h0058);
    step(1);
    check("pp_addr_c11", bus.mem_addr, 16'h0059);
    step(1);
    check("pp_req_c12", bus.mem_req, 0);
    expect_entry(16'h0052, 16'h0062, 16'h0063);
    expect_entry(16'h0054, 16'h0064, 16'h0065);
    expect_entry(16'h0056, 16'h0066, 16'h0067);
    expect_entry(16'h0058, 16'h0068, 16'h0069);
    drain("drain_pushpop", 40);

    // Fetch across the top of the address space
    do_redirect(16'hFFFF);
    step(1);
    check("wrap_addr_instr", bus.mem_addr, 16'hFFFF);
    step(1);
    check("wrap_addr_imm", bus.mem_addr, 16'h0000);
    step(1);
    check("wrap_addr_next", bus.mem_addr, 16'h0001);
    expect_entry(16'hFFFF, 16'h000F, 16'h0010);
    expect_entry(16'h0001, 16'h0011, 16'h0012);
    drain("drain_wrap", 30);

    step(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Prefetching instruction fetch unit between program memory and the single-cycle `cpu` core. It reads each two-word instruction (opcode word at address A, immediate word at A+1) over a req/ack memory port and queues {pc, instr, imm} entries in a small FIFO. The core drains the FIFO with a valid/ready handshake, which decouples it from memory wait states. A branch redirect flushes the queue and restarts fetching at the new address.

## Interface
Parameters:
- DEPTH, 4: FIFO entries; power of two, ≥2
- RESET_PC, 0: first fetch address after reset (`word`)

Ports:
- clk  in  1  system clock; one clock, all state on rising edge
- rst  in  1  reset; asynchronous and active-low
- redirect  in  1  core requests a fetch restart (taken branch/jump)
- redirect_pc  in  word  restart address, sampled when redirect=1
- out_valid  out  1  head FIFO entry is valid
- out_ready  in  1  core accepts the head entry
- out_pc  out  word  address of the head instruction
- out_instr  out  word  opcode word of the head entry
- out_imm  out  word  immediate word of the head entry
- mem_addr  out  word  program-memory read address
- mem_req  out  1  read request; held until mem_ack
- mem_ack  in  1  read complete; mem_rd_data valid in the same cycle
- mem_rd_data  in  word  read data

## Operation
- State `e_fetch_state`: F_IDLE, F_INSTR, F_IMM.
- Registers: fetch pointer fpc, held opcode hold_instr, hold_pc, FIFO count.
- F_IDLE: mem_req=0. Next state is F_INSTR if count<DEPTH, otherwise stay in F_IDLE.
- F_INSTR: mem_req=1, mem_addr=fpc. On ack: hold_instr←data, hold_pc←fpc, fpc←fpc+1, go to F_IMM.
- F_IMM: mem_req=1, mem_addr=fpc. On ack: push {hold_pc, hold_instr, data}, fpc←fpc+1. Go to F_INSTR if there is space after the push, else F_IDLE.
- The slot is reserved on F_INSTR entry. The unit is the only producer, so a push never finds the FIFO full.
- Pop: out_valid & out_ready. Push and pop in the same cycle leave count unchanged.
- fpc and its +1 wrap modulo 2^word width. No fault at the wrap.
- Redirect has the highest priority:
  - count←0, fpc←redirect_pc, state←F_IDLE.
  - An ack or pop in the same cycle is discarded; that entry is lost.
  - The pending request is abandoned; mem_req is 0 in the cycle after.
- Back-to-back redirects: the last one wins.
- With no redirect the stream is strictly sequential: out_pc increases by 2 per entry.

## Timing
- During reset and in the first cycle after release, all outputs are 0: mem_req, out_valid, mem_addr, out_pc, out_instr, out_imm. State resets to F_IDLE with fpc=RESET_PC.
- While mem_req=1, mem_addr is stable until ack or redirect.
- Zero-wait memory (ack in the request cycle): one instruction every 2 cycles.
- Push to out_valid takes 1 cycle (registered). Redirect to first out_valid is at least 4 cycles.
- Out data is stable while out_valid=1 and out_ready=0.

## Configuration
- `IFETCH_BYPASS_EN` defined:
  - When the FIFO is empty and the F_IMM ack arrives, out_valid and the out_* fields are driven combinationally from hold regs and mem_rd_data in the same cycle.
  - If out_ready=1 in that cycle, the entry is consumed without being written to the FIFO. Otherwise it is pushed.
  - Redirect still suppresses the bypass.
- Undefined: the entry is always pushed, and out_valid follows one cycle later. Outputs are purely registered or FIFO-read.

## Structure
- Add `e_fetch_state` to `project_pkg`, plus a `fetch_entry_t` struct {pc, instr, imm} built from `word`.
- One sub-module, `fetch_fifo`:
  - Parameter DEPTH; push, pop, flush, count, full, empty.
  - Storage is a register array with wrapping read/write pointers.
  - Flush resets both pointers.

## Test plan
- Reset release, zero-wait memory returning data=addr+0x10 → mem_addr sequence 0,1,2,3…. First entry is pc=0, instr=0x10, imm=0x11, with out_valid in the 4th cycle after release (3rd with `IFETCH_BYPASS_EN`).
- out_ready=0 held → exactly DEPTH entries are queued, then mem_req=0. One pop → exactly one new instruction is fetched.
- mem_ack delayed 3 cycles → mem_addr/mem_req are held stable, and the entries are correct.
- redirect to 0x40 while in F_IMM with a simultaneous ack → that entry is dropped, mem_req=0 for one cycle, the next fetch address is 0x40, and the first out_pc is 0x40.
- Simultaneous push and pop with count=DEPTH-1 → count unchanged, order preserved.
- Fetch across the top of the address space (fpc=max) → the imm is read from address 0, and the next instruction starts at address 1.
